// File: rtl/hex_dump_tx.sv
// Memory-to-UART hex dumper: reads words [0..last_idx] and transmits each as
// uppercase ASCII hex (MSB nibble first), optionally followed by CR/LF.
module hex_dump_tx #(
  parameter int WORD_W    = 32,
  parameter int ADDR_W    = 4,
  parameter int SEND_CRLF = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] last_idx,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [WORD_W-1:0] rd_data,
  output logic [7:0]        tx_din,
  output logic              tx_wr_en,
  input  logic              tx_busy,
  output logic              busy,
  output logic              done
);

  localparam int NIBBLES = WORD_W / 4;
  localparam int CNT_W   = $clog2(NIBBLES + 1);

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_READ  = 4'd1;
  localparam logic [3:0] S_LATCH = 4'd2;
  localparam logic [3:0] S_EMIT  = 4'd3;
  localparam logic [3:0] S_GUARD = 4'd4;
  localparam logic [3:0] S_WAIT  = 4'd5;
  localparam logic [3:0] S_CR    = 4'd6;
  localparam logic [3:0] S_LF    = 4'd7;
  localparam logic [3:0] S_NEXT  = 4'd8;

  // Remembers which character was just strobed so WAIT knows where to go next.
  localparam logic [1:0] PH_HEX = 2'd0;
  localparam logic [1:0] PH_CR  = 2'd1;
  localparam logic [1:0] PH_LF  = 2'd2;

  logic [3:0]        state;
  logic [1:0]        phase;
  logic [ADDR_W-1:0] last_q;
  logic [WORD_W-1:0] shift;
  logic [CNT_W-1:0]  nib_cnt;

  function automatic logic [7:0] to_ascii(input logic [3:0] nib);
    if (nib < 4'd10) return 8'h30 + {4'b0000, nib};
    else             return 8'h37 + {4'b0000, nib};
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      phase    <= PH_HEX;
      last_q   <= '0;
      shift    <= '0;
      nib_cnt  <= '0;
      rd_addr  <= '0;
      tx_din   <= 8'h00;
      tx_wr_en <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      tx_wr_en <= 1'b0;
      done     <= 1'b0;
      case (state)
        S_IDLE: begin
          // done is still high on the first IDLE cycle; a start then is dropped.
          if (start && !done) begin
            last_q  <= last_idx;
            rd_addr <= '0;
            busy    <= 1'b1;
            state   <= S_READ;
          end
        end
        S_READ:  state <= S_LATCH;
        S_LATCH: begin
          shift   <= rd_data;
          nib_cnt <= '0;
          state   <= S_EMIT;
        end
        S_EMIT: begin
          if (!tx_busy) begin
            tx_din   <= to_ascii(shift[WORD_W-1 -: 4]);
            tx_wr_en <= 1'b1;
            shift    <= shift << 4;
            nib_cnt  <= nib_cnt + 1'b1;
            phase    <= PH_HEX;
            state    <= S_GUARD;
          end
        end
        // The UART only raises busy one cycle after the strobe, so skip a cycle.
        S_GUARD: state <= S_WAIT;
        S_WAIT: begin
          if (!tx_busy) begin
            case (phase)
              PH_HEX: begin
                if (nib_cnt < CNT_W'(NIBBLES)) state <= S_EMIT;
                else if (SEND_CRLF != 0)       state <= S_CR;
                else                           state <= S_NEXT;
              end
              PH_CR:   state <= S_LF;
              default: state <= S_NEXT;
            endcase
          end
        end
        S_CR: begin
          if (!tx_busy) begin
            tx_din   <= 8'h0D;
            tx_wr_en <= 1'b1;
            phase    <= PH_CR;
            state    <= S_GUARD;
          end
        end
        S_LF: begin
          if (!tx_busy) begin
            tx_din   <= 8'h0A;
            tx_wr_en <= 1'b1;
            phase    <= PH_LF;
            state    <= S_GUARD;
          end
        end
        S_NEXT: begin
          if (rd_addr == last_q) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            rd_addr <= rd_addr + 1'b1;
            state   <= S_READ;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hex_dump_tx.sv
// Bench for hex_dump_tx: two instances (with and without CR/LF) share stimulus,
// each backed by a registered memory and a UART model busy 10 cycles per byte.
module tb_hex_dump_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  last_idx = 4'd0;

  logic [3:0]  rd_addr, rd_addr_nc;
  logic [31:0] rd_data, rd_data_nc;
  logic [7:0]  tx_din, tx_din_nc;
  logic        tx_wr_en, tx_wr_en_nc;
  logic        tx_busy, tx_busy_nc;
  logic        busy, busy_nc;
  logic        done, done_nc;

  logic [31:0] mem [16];
  int          busy_cnt, busy_cnt_nc;

  int tests = 0;
  int fails = 0;

  byte cap[$];
  byte cap_nc[$];
  int  viol_busy, viol_b2b, done_cnt, done_cnt_nc, max_addr, wraps;
  logic prev_wr, prev_wr_nc, prev_busy;
  logic [3:0] prev_addr;

  typedef struct {
    string       name;
    logic [31:0] w0, w1, w2;
    logic [3:0]  last;
    string       hex;
  } vec_t;

  always #5 clk = ~clk;

  hex_dump_tx #(.WORD_W(32), .ADDR_W(4), .SEND_CRLF(1)) dut (
    .clk(clk), .rst(rst), .start(start), .last_idx(last_idx),
    .rd_addr(rd_addr), .rd_data(rd_data), .tx_din(tx_din), .tx_wr_en(tx_wr_en),
    .tx_busy(tx_busy), .busy(busy), .done(done)
  );

  hex_dump_tx #(.WORD_W(32), .ADDR_W(4), .SEND_CRLF(0)) dut_nc (
    .clk(clk), .rst(rst), .start(start), .last_idx(last_idx),
    .rd_addr(rd_addr_nc), .rd_data(rd_data_nc), .tx_din(tx_din_nc), .tx_wr_en(tx_wr_en_nc),
    .tx_busy(tx_busy_nc), .busy(busy_nc), .done(done_nc)
  );

  // Registered memory read and UART busy models.
  always @(posedge clk) begin
    rd_data    <= mem[rd_addr];
    rd_data_nc <= mem[rd_addr_nc];
    if (rst) begin
      busy_cnt    <= 0;
      busy_cnt_nc <= 0;
    end else begin
      if (tx_wr_en) busy_cnt <= 10;
      else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
      if (tx_wr_en_nc) busy_cnt_nc <= 10;
      else if (busy_cnt_nc != 0) busy_cnt_nc <= busy_cnt_nc - 1;
    end
  end
  assign tx_busy    = (busy_cnt != 0);
  assign tx_busy_nc = (busy_cnt_nc != 0);

  // Output monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (tx_wr_en) begin
      cap.push_back(tx_din);
      if (tx_busy) viol_busy++;
      if (prev_wr) viol_b2b++;
    end
    if (tx_wr_en_nc) begin
      cap_nc.push_back(tx_din_nc);
      if (tx_busy_nc) viol_busy++;
      if (prev_wr_nc) viol_b2b++;
    end
    if (done) done_cnt++;
    if (done_nc) done_cnt_nc++;
    if (busy && int'(rd_addr) > max_addr) max_addr = int'(rd_addr);
    if (busy && prev_busy && rd_addr < prev_addr) wraps++;
    prev_wr   = tx_wr_en;
    prev_wr_nc = tx_wr_en_nc;
    prev_busy = busy;
    prev_addr = rd_addr;
  end

  task automatic check_output(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_monitor();
    cap.delete();
    cap_nc.delete();
    viol_busy = 0; viol_b2b = 0; done_cnt = 0; done_cnt_nc = 0;
    max_addr = 0; wraps = 0;
  endtask

  // Compare a captured stream against the hex text, with CR/LF after every 8 chars if crlf.
  task automatic check_stream(input string name, input string hex, input bit crlf);
    int  per = crlf ? 10 : 8;
    int  nw  = hex.len() / 8;
    int  bad = -1;
    int  n;
    byte e, a;
    n = crlf ? cap.size() : cap_nc.size();
    check_output({name, "_len"}, n, nw * per);
    for (int i = 0; i < n && i < nw * per; i++) begin
      if (i % per == 8)      e = 8'h0D;
      else if (i % per == 9) e = 8'h0A;
      else                   e = hex[(i / per) * 8 + (i % per)];
      a = crlf ? cap[i] : cap_nc[i];
      if (a != e && bad < 0) bad = i;
    end
    check_output({name, "_first_bad_char_pos"}, bad, -1);
  endtask

  // mode 0 plain, 1 disturb start/last_idx mid-dump, 2 start on the done cycle
  task automatic apply_stimulus(input logic [3:0] last, input int mode, input string name);
    bit seen = 0;
    @(negedge clk);
    clear_monitor();
    start = 1'b1; last_idx = last;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 6000 && !seen; c++) begin
      @(negedge clk);
      if (mode == 1 && c == 40) begin start = 1'b1; last_idx = 4'd0; end
      if (mode == 1 && c == 41) begin start = 1'b0; last_idx = 4'd7; end
      if (done) begin
        seen = 1;
        if (mode == 2) start = 1'b1;
      end
    end
    check_output({name, "_done_before_timeout"}, int'(seen), 1);
    @(negedge clk);
    start = 1'b0;
    repeat (30) @(negedge clk);
    check_output({name, "_busy_low_after"}, int'(busy), 0);
    check_output({name, "_done_pulses"}, done_cnt, 1);
    check_output({name, "_strobe_while_busy"}, viol_busy, 0);
    check_output({name, "_back_to_back"}, viol_b2b, 0);
  endtask

  vec_t vecs[3];
  string digits, hex16;
  bit reached;

  initial begin
    vecs[0] = '{"one_word",    32'h00A0_0113, 32'h0,         32'h0,         4'd0, "00A00113"};
    vecs[1] = '{"three_words", 32'hDEAD_BEEF, 32'h1234_5678, 32'hFFFF_FFFF, 4'd2,
                "DEADBEEF12345678FFFFFFFF"};
    vecs[2] = '{"two_words",   32'h0987_6543, 32'h0000_ABCD, 32'h0,         4'd1,
                "098765430000ABCD"};

    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    clear_monitor();
    repeat (3) @(negedge clk);
    check_output("reset_busy", int'(busy), 0);
    check_output("reset_wr_en", int'(tx_wr_en), 0);
    check_output("reset_done", int'(done), 0);
    check_output("reset_rd_addr", int'(rd_addr), 0);
    check_output("reset_tx_din", int'(tx_din), 0);
    rst = 1'b0;

    for (int v = 0; v < 3; v++) begin
      mem[0] = vecs[v].w0; mem[1] = vecs[v].w1; mem[2] = vecs[v].w2;
      apply_stimulus(vecs[v].last, 0, vecs[v].name);
      check_stream(vecs[v].name, vecs[v].hex, 1'b1);
      check_output({vecs[v].name, "_max_addr"}, max_addr, int'(vecs[v].last));
    end

    // All 16 words: the index must stop at 15 without wrapping.
    digits = "0123456789ABCDEF";
    hex16 = "";
    for (int i = 0; i < 16; i++) begin
      mem[i] = i;
      hex16 = {hex16, "0000000", digits.substr(i, i)};
    end
    apply_stimulus(4'd15, 0, "sixteen");
    check_stream("sixteen", hex16, 1'b1);
    check_output("sixteen_max_addr", max_addr, 15);
    check_output("sixteen_no_wrap", wraps, 0);
    check_output("sixteen_final_addr", int'(rd_addr), 15);

    // Without CR/LF.
    mem[0] = 32'hCAFE_0001;
    apply_stimulus(4'd0, 0, "no_crlf");
    check_stream("no_crlf", "CAFE0001", 1'b0);
    check_output("no_crlf_done_pulses", done_cnt_nc, 1);

    // Mid-dump start and last_idx changes are ignored.
    mem[0] = 32'hDEAD_BEEF; mem[1] = 32'h1234_5678; mem[2] = 32'hFFFF_FFFF;
    apply_stimulus(4'd2, 1, "disturbed");
    check_stream("disturbed", "DEADBEEF12345678FFFFFFFF", 1'b1);

    // start coincident with done is dropped.
    apply_stimulus(4'd0, 2, "start_on_done");
    check_output("start_on_done_extra_chars", cap.size(), 10);

    // Reset after the 5th character aborts the dump.
    @(negedge clk);
    clear_monitor();
    start = 1'b1; last_idx = 4'd2;
    @(negedge clk);
    start = 1'b0;
    reached = 0;
    for (int c = 0; c < 2000 && !reached; c++) begin
      @(negedge clk);
      if (cap.size() >= 5) reached = 1;
    end
    check_output("abort_reached_5_chars", int'(reached), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_output("abort_busy", int'(busy), 0);
    check_output("abort_wr_en", int'(tx_wr_en), 0);
    repeat (200) @(negedge clk);
    check_output("abort_no_more_chars", cap.size(), 5);
    apply_stimulus(4'd0, 0, "restart");
    check_stream("restart", "DEADBEEF", 1'b1);

    // start and rst together: reset wins.
    @(negedge clk);
    clear_monitor();
    start = 1'b1; rst = 1'b1;
    @(negedge clk);
    start = 1'b0; rst = 1'b0;
    check_output("start_rst_busy", int'(busy), 0);
    repeat (20) @(negedge clk);
    check_output("start_rst_still_idle", int'(busy), 0);
    check_output("start_rst_no_chars", cap.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
